// File: rtl/led_pkg.sv
// led_pkg: shared constants, scanner state type and
// LED_PANEL pin packing for the HUB75 scanner.
package led_pkg;

  localparam int PANEL_COLS      = 64;
  localparam int PANEL_HALF_ROWS = 32;
  localparam int SUBFRAMES       = 256;
  localparam int FRAME_W         = 13;

  typedef enum logic [2:0] {
    S_SHIFT = 3'd0,
    S_DRAIN = 3'd1,
    S_BLANK = 3'd2,
    S_LATCH = 3'd3,
    S_HOLD  = 3'd4
  } scan_state_t;

  // Bit positions inside the 16-bit LED_PANEL bus.
  localparam int LP_W   = 16;
  localparam int LP_R0  = 0;
  localparam int LP_R1  = 3;
  localparam int LP_A   = 6;
  localparam int LP_CLK = 11;
  localparam int LP_LAT = 12;
  localparam int LP_OE  = 13;

  function automatic logic [LP_W-1:0] led_pack(
    input logic [2:0] rgb0,
    input logic [2:0] rgb1,
    input logic [4:0] addr,
    input logic       clk,
    input logic       lat,
    input logic       oe_n
  );
    logic [LP_W-1:0] v;
    v              = '0;
    v[LP_R0 +: 3]  = rgb0;
    v[LP_R1 +: 3]  = rgb1;
    v[LP_A +: 5]   = addr;
    v[LP_CLK]      = clk;
    v[LP_LAT]      = lat;
    v[LP_OE]       = oe_n;
    return v;
  endfunction

endpackage

// File: rtl/led_scan_counters.sv
// led_scan_counters: row -> subframe -> frame divider
// -> frame cascade, stepped once per latched row.
module led_scan_counters
  import led_pkg::*;
#(
  parameter int FRAME_DIV = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               i_advance,
  output logic [4:0]         o_row,
  output logic [7:0]         o_subframe,
  output logic [FRAME_W-1:0] o_frame,
  output logic               o_row_wrap,
  output logic               o_sub_wrap
);

  localparam int DIV_W =
    (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(FRAME_DIV - 1);

  logic [4:0]         r_row;
  logic [7:0]         r_sub;
  logic [DIV_W-1:0]   r_div;
  logic [FRAME_W-1:0] r_frame;

  logic w_row_wrap;
  logic w_sub_wrap;
  logic w_div_wrap;

  assign w_row_wrap = i_advance &&
    (r_row == 5'(PANEL_HALF_ROWS - 1));
  assign w_sub_wrap = w_row_wrap &&
    (r_sub == 8'(SUBFRAMES - 1));
  assign w_div_wrap = w_sub_wrap &&
    (r_div == DIV_LAST);

  // Ripple the cascade; each level steps on the wrap below it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_row   <= '0;
      r_sub   <= '0;
      r_div   <= '0;
      r_frame <= '0;
    end else begin
      if (i_advance)
        r_row <= r_row + 5'd1;
      if (w_row_wrap)
        r_sub <= r_sub + 8'd1;
      if (w_sub_wrap)
        r_div <= w_div_wrap ? '0 : r_div + 1'b1;
      if (w_div_wrap)
        r_frame <= r_frame + 1'b1;
    end
  end

  assign o_row      = r_row;
  assign o_subframe = r_sub;
  assign o_frame    = r_frame;
  assign o_row_wrap = w_row_wrap;
  assign o_sub_wrap = w_sub_wrap;

endmodule

// File: rtl/led_scanner.sv
// led_scanner: queries the painter pixel by pixel and
// serialises row pairs onto a 64x64 1/32-scan HUB75 panel.
module led_scanner
  import led_pkg::*;
#(
  parameter int HOLD_CYCLES = 0,
  parameter int FRAME_DIV   = 1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [12:0] frame,
  output logic [7:0]  subframe,
  output logic [5:0]  x,
  output logic [5:0]  y,
  input  logic [2:0]  rgb,
  output logic [2:0]  led_rgb0,
  output logic [2:0]  led_rgb1,
  output logic [4:0]  led_addr,
  output logic        led_clk,
  output logic        led_lat,
  output logic        led_oe_n
);

  localparam int HW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST =
    HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  scan_state_t r_state;
  scan_state_t w_next;

  logic [5:0]    r_col;
  logic          r_phase;
  logic          r_drain;
  logic [HW-1:0] r_hold;
  logic [2:0]    r_top_q;
  logic [2:0]    r_rgb0;
  logic [2:0]    r_rgb1;
  logic [4:0]    r_addr;
  logic          r_clk;
  logic          r_lat;
  logic          r_oe_n;
  logic          r_armed;

  logic [4:0] w_row;
  logic       w_advance;
  logic       w_last;
  logic       w_blank_next;
  logic       w_row_wrap;
  logic       w_sub_wrap;
  logic       w_unused;

  assign w_advance = (r_state == S_LATCH);
  assign w_last    = r_phase &&
    (r_col == 6'(PANEL_COLS - 1));
  assign w_blank_next =
    (w_next == S_BLANK) || (w_next == S_LATCH);
  assign w_unused  = ^{w_row_wrap, w_sub_wrap};

  led_scan_counters #(
    .FRAME_DIV (FRAME_DIV)
  ) u_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .i_advance  (w_advance),
    .o_row      (w_row),
    .o_subframe (subframe),
    .o_frame    (frame),
    .o_row_wrap (w_row_wrap),
    .o_sub_wrap (w_sub_wrap)
  );

  // Scan state register.
  always_ff @(posedge clk) begin
    if (!resetn)
      r_state <= S_SHIFT;
    else
      r_state <= w_next;
  end

  // Row sequencing: shift, drain, blank, latch, hold.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_SHIFT: if (w_last) w_next = S_DRAIN;
      S_DRAIN: if (r_drain) w_next = S_BLANK;
      S_BLANK: w_next = S_LATCH;
      S_LATCH:
        w_next = (HOLD_CYCLES == 0) ? S_SHIFT : S_HOLD;
      S_HOLD:
        if (r_hold == HOLD_LAST) w_next = S_SHIFT;
      default: w_next = S_SHIFT;
    endcase
  end

  // Pixel pair capture and registered panel strobes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_col   <= '0;
      r_phase <= 1'b0;
      r_drain <= 1'b0;
      r_hold  <= '0;
      r_top_q <= '0;
      r_rgb0  <= '0;
      r_rgb1  <= '0;
      r_addr  <= '0;
      r_clk   <= 1'b0;
      r_lat   <= 1'b0;
      r_oe_n  <= 1'b1;
      r_armed <= 1'b0;
    end else begin
      unique case (r_state)
        S_SHIFT: begin
          if (!r_phase) begin
            r_top_q <= rgb;
            r_phase <= 1'b1;
          end else begin
            r_rgb0 <= r_top_q;
            r_rgb1 <= rgb;
            if (!w_last) begin
              r_phase <= 1'b0;
              r_col   <= r_col + 6'd1;
            end
          end
        end
        S_DRAIN: r_drain <= ~r_drain;
        S_LATCH: begin
          r_col   <= '0;
          r_phase <= 1'b0;
          r_armed <= 1'b1;
        end
        S_HOLD:
          r_hold <= (w_next == S_SHIFT) ?
            '0 : r_hold + 1'b1;
        default: ;
      endcase
      // Rising edge one cycle after each data update.
      r_clk <=
        ((r_state == S_SHIFT) && !r_phase &&
         (r_col != 6'd0)) ||
        ((r_state == S_DRAIN) && !r_drain);
      r_lat <= (w_next == S_LATCH);
      if (w_next == S_LATCH)
        r_addr <= w_row;
      // Dark until the first row has been latched.
      r_oe_n <= w_blank_next ||
        !(r_armed || (r_state == S_LATCH));
    end
  end

  assign x        = r_col;
  assign y        = {r_phase, w_row};
  assign led_rgb0 = r_rgb0;
  assign led_rgb1 = r_rgb1;
  assign led_addr = r_addr;
  assign led_clk  = r_clk;
  assign led_lat  = r_lat;
  assign led_oe_n = r_oe_n;

endmodule

// File: tb/tb_led_scanner.sv
// tb_led_scanner: timeline reference model for two
// scanner builds (hold 0 and 5) plus the counter cascade.
module tb_led_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn = 1'b0;
  int   mode = 0;
  logic [2:0] pix [0:4095];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tq = 0;
  bit   mon_en = 1'b0;

  function automatic logic [2:0] paint(
    input logic [5:0] px, input logic [5:0] py);
    case (mode)
      0: return px[2:0];
      1: return py[5] ? 3'b101 : 3'b010;
      default: return pix[{py, px}];
    endcase
  endfunction

  logic [12:0] a_fr, b_fr;
  logic [7:0]  a_sf, b_sf;
  logic [5:0]  a_x, a_y, b_x, b_y;
  logic [2:0]  a_rgb, b_rgb;
  logic [2:0]  a_d0, a_d1, b_d0, b_d1;
  logic [4:0]  a_ad, b_ad;
  logic        a_ck, a_lt, a_oe, b_ck, b_lt, b_oe;

  always_comb a_rgb = paint(a_x, a_y);
  always_comb b_rgb = paint(b_x, b_y);

  led_scanner #(.HOLD_CYCLES(0), .FRAME_DIV(1)) u_a (
    .clk(clk), .resetn(resetn), .frame(a_fr),
    .subframe(a_sf), .x(a_x), .y(a_y), .rgb(a_rgb),
    .led_rgb0(a_d0), .led_rgb1(a_d1), .led_addr(a_ad),
    .led_clk(a_ck), .led_lat(a_lt), .led_oe_n(a_oe));

  led_scanner #(.HOLD_CYCLES(5), .FRAME_DIV(1)) u_b (
    .clk(clk), .resetn(resetn), .frame(b_fr),
    .subframe(b_sf), .x(b_x), .y(b_y), .rgb(b_rgb),
    .led_rgb0(b_d0), .led_rgb1(b_d1), .led_addr(b_ad),
    .led_clk(b_ck), .led_lat(b_lt), .led_oe_n(b_oe));

  logic [46:0] a_vec, b_vec;
  assign a_vec = {a_fr, a_sf, a_x, a_y, a_d0, a_d1,
                  a_ad, a_ck, a_lt, a_oe};
  assign b_vec = {b_fr, b_sf, b_x, b_y, b_d0, b_d1,
                  b_ad, b_ck, b_lt, b_oe};

  logic        cnt_rstn = 1'b0;
  logic        cnt_adv = 1'b0;
  logic [4:0]  c1_row, c2_row;
  logic [7:0]  c1_sf, c2_sf;
  logic [12:0] c1_fr, c2_fr;
  logic        c1_rw, c1_sw, c2_rw, c2_sw;

  led_scan_counters #(.FRAME_DIV(1)) u_c1 (
    .clk(clk), .resetn(cnt_rstn), .i_advance(cnt_adv),
    .o_row(c1_row), .o_subframe(c1_sf), .o_frame(c1_fr),
    .o_row_wrap(c1_rw), .o_sub_wrap(c1_sw));

  led_scan_counters #(.FRAME_DIV(2)) u_c2 (
    .clk(clk), .resetn(cnt_rstn), .i_advance(cnt_adv),
    .o_row(c2_row), .o_subframe(c2_sf), .o_frame(c2_fr),
    .o_row_wrap(c2_rw), .o_sub_wrap(c2_sw));

  // Cycles since the last reset edge (0 = first free cycle).
  always @(posedge clk) begin
    if (!resetn) tq <= 0;
    else tq <= tq + 1;
  end

  // Row timeline: shift 0..127, drain 128..129,
  // blank 130, latch 131, hold 132.. ; period 132+h.
  function automatic logic [46:0] exp_vec(
    input int h, input int t);
    int P, p, row, done, j;
    logic [5:0] ex, ey;
    logic [2:0] e0, e1;
    logic [4:0] ea;
    logic ec, el, eo;
    P = 132 + h;
    p = t % P;
    row = (t / P) % 32;
    done = (t + h) / P;
    ex = '0; ey = '0; e0 = '0; e1 = '0;
    if (p < 128) begin
      ex = 6'(p / 2);
      ey = {1'(p % 2), 5'(row)};
    end else if (p < 130) begin
      ex = 6'd63;
      ey = {1'b1, 5'(row)};
    end
    ec = ((p < 128) && (p % 2 == 1) && (p >= 3)) ||
         (p == 129);
    if (ec) begin
      j = (p == 129) ? 63 : (p - 3) / 2;
      e0 = paint(6'(j), {1'b0, 5'(row)});
      e1 = paint(6'(j), {1'b1, 5'(row)});
    end
    ea = (t < 131) ? 5'd0 : 5'(((t - 131) / P) % 32);
    el = (p == 131);
    eo = (t < 132) || (p == 130) || (p == 131);
    return {13'((done / 8192) % 8192),
            8'((done / 32) % 256),
            ex, ey, e0, e1, ea, ec, el, eo};
  endfunction

  function automatic logic [46:0] exp_mask(
    input int h, input int t);
    int p;
    logic ec;
    p = t % (132 + h);
    ec = ((p < 128) && (p % 2 == 1) && (p >= 3)) ||
         (p == 129);
    return {21'h1fffff,
            (p < 130) ? 12'hfff : 12'h000,
            ec ? 6'h3f : 6'h00, 8'hff};
  endfunction

  logic [46:0] m_e, m_m;

  always @(negedge clk) begin
    if (mon_en) begin
      m_e = exp_vec(0, tq);
      m_m = exp_mask(0, tq);
      n_cmp++;
      if ((a_vec & m_m) !== (m_e & m_m)) begin
        n_bad++;
        $display("FAIL timeline_h0 t=%0d got=%h exp=%h",
                 tq, a_vec & m_m, m_e & m_m);
      end
      m_e = exp_vec(5, tq);
      m_m = exp_mask(5, tq);
      n_cmp++;
      if ((b_vec & m_m) !== (m_e & m_m)) begin
        n_bad++;
        $display("FAIL timeline_h5 t=%0d got=%h exp=%h",
                 tq, b_vec & m_m, m_e & m_m);
      end
    end
  end

  task automatic do_reset(input int n);
    @(negedge clk);
    resetn = 1'b0;
    repeat (n) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    int first, rises, lat_at, rises_lat;
    logic prev;
    logic [2:0] d_first;
    mon_en = 1'b0;
    mode = 0;
    @(negedge clk);
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (a_vec !== 47'h1 || b_vec !== 47'h1) begin
        n_bad++;
        $display("FAIL reset_state got=%h/%h exp=%h",
                 a_vec, b_vec, 47'h1);
      end
    end
    resetn = 1'b1;
    mon_en = 1'b1;
    first = -1; rises = 0; lat_at = -1;
    rises_lat = -1; prev = 1'b0; d_first = 3'h7;
    for (int i = 0; i < 140; i++) begin
      if (a_ck && !prev) begin
        if (first < 0) begin
          first = i;
          d_first = a_d0;
        end
        rises++;
      end
      if (a_lt && lat_at < 0) begin
        lat_at = i;
        rises_lat = rises;
      end
      prev = a_ck;
      @(negedge clk);
    end
    n_cmp++;
    if (first != 3) begin
      n_bad++;
      $display("FAIL first_rise got=%0d exp=3", first);
    end
    n_cmp++;
    if (d_first !== 3'd0) begin
      n_bad++;
      $display("FAIL first_data got=%0d exp=0", d_first);
    end
    n_cmp++;
    if (rises_lat != 64) begin
      n_bad++;
      $display("FAIL rises_before_lat got=%0d exp=64",
               rises_lat);
    end
    n_cmp++;
    if (lat_at != 131) begin
      n_bad++;
      $display("FAIL first_lat got=%0d exp=131", lat_at);
    end
  endtask

  task automatic test_halves();
    logic pa, pb;
    mon_en = 1'b0;
    mode = 1;
    do_reset(2);
    mon_en = 1'b1;
    pa = 1'b0; pb = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (a_ck && !pa) begin
        n_cmp++;
        if ({a_d0, a_d1} !== 6'b010_101) begin
          n_bad++;
          $display("FAIL halves_a got=%b exp=010101",
                   {a_d0, a_d1});
        end
      end
      if (b_ck && !pb) begin
        n_cmp++;
        if ({b_d0, b_d1} !== 6'b010_101) begin
          n_bad++;
          $display("FAIL halves_b got=%b exp=010101",
                   {b_d0, b_d1});
        end
      end
      pa = a_ck; pb = b_ck;
      @(negedge clk);
    end
  endtask

  task automatic test_random_rows();
    int la, lb, na, nb;
    mon_en = 1'b0;
    mode = 2;
    for (int i = 0; i < 4096; i++)
      pix[i] = 3'($urandom);
    do_reset(2);
    mon_en = 1'b1;
    la = 0; lb = 0; na = 0; nb = 0;
    for (int i = 0; i < 13000; i++) begin
      if (a_lt) begin
        if (na > 0) begin
          n_cmp++;
          if (i - la != 132) begin
            n_bad++;
            $display("FAIL period_h0 got=%0d exp=132",
                     i - la);
          end
        end
        n_cmp++;
        if ({a_ad, a_sf} !==
            {5'(na % 32), 8'((na / 32) % 256)}) begin
          n_bad++;
          $display("FAIL addr_sub_h0 got=%0d/%0d exp=%0d/%0d",
                   a_ad, a_sf, na % 32, (na / 32) % 256);
        end
        la = i;
        na++;
      end
      if (b_lt) begin
        if (nb > 0) begin
          n_cmp++;
          if (i - lb != 137) begin
            n_bad++;
            $display("FAIL period_h5 got=%0d exp=137",
                     i - lb);
          end
        end
        lb = i;
        nb++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_midrow_reset();
    bit found;
    mon_en = 1'b0;
    mode = 2;
    do_reset(2);
    mon_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (tq == 7 * 132 + 60) found = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!found || a_x !== 6'd30 || a_y !== 6'd7) begin
      n_bad++;
      $display("FAIL midrow_reach got=%0d,%0d exp=30,7",
               a_x, a_y);
    end
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    n_cmp++;
    if ({a_x, a_y, a_oe, a_ad, a_fr, a_sf} !==
        {6'd0, 6'd0, 1'b1, 5'd0, 13'd0, 8'd0}) begin
      n_bad++;
      $display("FAIL midrow_reset got=%0d %0d %b %0d %0d %0d",
               a_x, a_y, a_oe, a_ad, a_fr, a_sf);
    end
    repeat (400) @(negedge clk);
    mon_en = 1'b0;
  endtask

  task automatic test_counter_wrap();
    logic [28:0] g1, e1, g2, e2;
    @(negedge clk);
    cnt_rstn = 1'b0;
    @(negedge clk);
    cnt_rstn = 1'b1;
    cnt_adv = 1'b1;
    for (int n = 0; n < 16400; n++) begin
      g1 = {c1_row, c1_sf, c1_fr, c1_rw, c1_sw};
      e1 = {5'(n % 32), 8'((n / 32) % 256),
            13'((n / 8192) % 8192), n % 32 == 31,
            n % 8192 == 8191};
      g2 = {c2_row, c2_sf, c2_fr, c2_rw, c2_sw};
      e2 = {5'(n % 32), 8'((n / 32) % 256),
            13'((n / 16384) % 8192), n % 32 == 31,
            n % 8192 == 8191};
      n_cmp++;
      if (g1 !== e1) begin
        n_bad++;
        $display("FAIL cnt_div1 n=%0d got=%h exp=%h",
                 n, g1, e1);
      end
      n_cmp++;
      if (g2 !== e2) begin
        n_bad++;
        $display("FAIL cnt_div2 n=%0d got=%h exp=%h",
                 n, g2, e2);
      end
      @(negedge clk);
    end
    cnt_adv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_halves();
    test_random_rows();
    test_midrow_reset();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_scanner.md
Name: led_scanner

Overview:
- Drives a 64x64, 1/32-scan HUB75 panel and is the opposite end of the painter interface.
- It generates the frame, subframe, x and y query sequence, samples the painter's rgb answer, and serialises pixel pairs (rows r and r+32) onto the panel.
- It also produces the shift clock, latch, row address and output-enable.
- It sits inside led_main, between the painter and the packed LED_PANEL pins.

Parameters:
- HOLD_CYCLES, 0, extra cycles per row that the LEDs stay enabled after latch before the next shift begins (brightness trim).
- FRAME_DIV, 1, number of full subframe sweeps (256 subframes each) per frame increment; must be >= 1.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- frame  out  13  current frame number to painter
- subframe  out  8  current PWM subframe to painter
- x  out  6  pixel column being queried
- y  out  6  pixel row being queried (bit 5 selects lower half)
- rgb  in  3  painter answer for (x,y); combinational, sampled in the same cycle
- led_rgb0  out  3  upper-half pixel data {r,g,b}
- led_rgb1  out  3  lower-half pixel data
- led_addr  out  5  row address
- led_clk  out  1  panel shift clock; data is sampled on its rising edge
- led_lat  out  1  panel latch strobe
- led_oe_n  out  1  panel output enable, active-low

Behaviour:
- Reset (resetn=0 at a clk edge):
  - All counters, outputs and state go to 0, except led_oe_n=1.
  - State becomes SHIFT with col=0, phase=0, row=0.
  - A reset mid-row aborts it immediately; the first row after reset is shifted with the LEDs blanked.
- States: SHIFT, DRAIN, BLANK, LATCH, HOLD.
- SHIFT (128 cycles):
  - The col counter (0..63) and phase bit alternate.
  - Phase 0: x=col, y={0,row}; register rgb into top_q.
  - Phase 1: x=col, y={1,row}; register led_rgb0<=top_q and led_rgb1<=rgb.
  - led_clk is registered high for the one cycle after each data update (phase-0 query cycle of the next column).
  - Data is therefore stable for 1 cycle before the rising edge and holds through the high cycle.
  - Query-to-pin latency is 2 cycles.
- DRAIN (2 cycles): outputs the last column's clk-low and clk-high cycles; x/y are held at the last query.
- BLANK (1 cycle): led_oe_n=1, led_clk=0.
- LATCH (1 cycle):
  - led_lat=1, led_addr<=row, led_oe_n stays 1.
  - The counters advance: row++; on row wrap 31->0, subframe++; on subframe wrap 255->0, the frame-divider counter advances, and frame++ when it reaches FRAME_DIV-1.
  - frame wraps 8191->0.
- HOLD (HOLD_CYCLES cycles, skipped when 0): led_oe_n=0, no shifting. Next state is SHIFT.
- After the first LATCH following reset, led_oe_n=0 in every state except BLANK and LATCH.
- Row period = 132+HOLD_CYCLES cycles.
- frame and subframe change only at LATCH, so they are constant across all 128 queries of a row.
- led_lat and led_clk are never high in the same cycle.
- led_addr changes only in LATCH, while led_oe_n=1.

Decomposition:
- Shared package led_pkg holds:
  - constants PANEL_COLS=64, PANEL_HALF_ROWS=32, SUBFRAMES=256, FRAME_W=13;
  - the scanner state enum;
  - the 16-bit LED_PANEL bit-position constants used by the packing wrapper.
- Natural sub-module: led_scan_counters. It holds the row/subframe/frame-divider/frame cascade with a single advance input and wrap outputs.
- The FSM and the shift datapath stay in led_scanner.

Test Plan:
- Reset release with a stub painter returning rgb=x[2:0] -> led_oe_n=1 and all other outputs 0 during reset; first led_clk rise 3 cycles after release; led_rgb0=3'd0 at the first rise; 64 rising edges before the first led_lat.
- Painter stub returning rgb=y[5]?3'b101:3'b010 -> at every led_clk rise led_rgb0=3'b010 and led_rgb1=3'b101.
- Timing with HOLD_CYCLES=0 -> led_lat pulses are 132 cycles apart; led_addr increments 0,1,...,31,0; led_oe_n is high exactly on the BLANK and LATCH cycles after the first latch.
- Counter wrap (32*256 rows, FRAME_DIV=1) -> subframe increments every 32 latches; frame goes 0->1 at the latch where subframe wraps 255->0.
- HOLD_CYCLES=5 -> row period 137; led_oe_n=0 and led_clk=0 for the 5 cycles after LATCH.
- resetn pulsed low at col 30 of row 7 -> the next cycle shows row 0, col 0, led_oe_n=1, led_addr=0, frame=0, subframe=0.
